uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Four-requester round-robin arbiter feeding a single UART sender.
// One word slot per requester; a SEND timeout drops a stuck word and counts it as an error.
module uart_tx_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           req_valid,
  input  logic [4*WIDTH-1:0]   req_data,
  output logic [3:0]           req_ready,
  output logic                 send,
  output logic [WIDTH-1:0]     data,
  input  logic                 send_done,
  output logic [1:0]           tx_src,
  output logic                 busy,
  output logic                 err,
  output logic [15:0]          sent_cnt,
  output logic [7:0]           err_cnt
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] slot [4];
  logic [3:0]       full;
  logic [3:0]       set_full;
  logic [3:0]       clr_full;
  logic [1:0]       last_grant;
  logic [1:0]       grant_idx;
  logic [1:0]       cand;
  logic             grant_vld;
  logic [15:0]      tcnt;
  logic             done_evt;
  logic             tout_evt;

  assign req_ready = ~full;

  // Scan starts one past the last grant so a constantly refilled requester cannot starve the others.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = last_grant;
    cand      = last_grant;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant + 2'(k);
      if (!grant_vld && full[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Completion wins over an expiry landing on the same cycle.
  assign done_evt = (state == SEND) && send_done;
  assign tout_evt = (state == SEND) && !send_done && (tcnt == TLAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = SEND;
      SEND:    if (done_evt || tout_evt) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    set_full = req_valid & ~full;
    clr_full = 4'b0000;
    if (done_evt || tout_evt) clr_full = 4'b0001 << tx_src;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      send       <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      data       <= '0;
      tx_src     <= 2'd0;
      last_grant <= 2'd3;
      full       <= 4'b0000;
      sent_cnt   <= 16'd0;
      err_cnt    <= 8'd0;
      tcnt       <= 16'd0;
      for (int i = 0; i < 4; i++) slot[i] <= '0;
    end else begin
      state <= state_nxt;
      send  <= (state_nxt == SEND);
      busy  <= (state_nxt != IDLE);
      err   <= tout_evt;
      full  <= (full & ~clr_full) | set_full;
      for (int i = 0; i < 4; i++)
        if (set_full[i]) slot[i] <= req_data[i*WIDTH +: WIDTH];
      if (state == IDLE && grant_vld) begin
        data       <= slot[grant_idx];
        tx_src     <= grant_idx;
        last_grant <= grant_idx;
      end
      if (state == SEND) tcnt <= tcnt + 16'd1;
      else               tcnt <= 16'd0;
      if (done_evt) sent_cnt <= sent_cnt + 16'd1;
      if (tout_evt && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule
